router_dst_channel: RTL and testbench
=====================================

// Module: router_dst_channel
// PURPOSE
//  Router output channel: one per destination port, driving the signals the destination consumes.
//  Buffers bytes written by the router FSM, presents vld_out while data is pending, and returns data_out after rd_enb.
//  A watchdog flushes the channel with a soft reset if the destination ignores valid data for TIMEOUT cycles.
//  Three instances sit between the router FSM/synchroniser and the three destination ports.
// PARAMETERS
//  DEPTH    16  FIFO entries (power of 2); pointers are log2(DEPTH)+1 bits including a wrap bit
//  TIMEOUT  30  consecutive cycles of vld_out=1 && rd_enb=0 that trigger a soft reset
// PORTS
//  clock       in   1  single clock; all logic on posedge
//  resetn      in   1  asynchronous, active-low reset
//  write_enb   in   1  write data_in this cycle (router FSM)
//  lfd_state   in   1  data_in is a packet header byte; stored as tag bit 8
//  data_in     in   8  byte from router FSM
//  rd_enb      in   1  destination read request
//  data_out    out  8  read byte, registered
//  vld_out     out  1  channel non-empty
//  full        out  1  DEPTH entries held
//  soft_reset  out  1  one-cycle pulse: watchdog expired, channel flushed
//  pkt_done    out  1  one-cycle pulse: parity byte of a packet delivered on data_out
// BEHAVIOUR
//  Reset (resetn=0, async): pointers, count, watchdog and byte counter = 0; data_out=8'h00;
//   vld_out=0; full=0; soft_reset=0; pkt_done=0.
//  Storage: DEPTH x 9 bits {lfd, byte}; full = ptr MSBs differ and LSBs equal; empty = ptrs equal.
//  vld_out = !empty (combinational from pointers); full combinational from pointers.
//  Write: write_enb && !full stores {lfd_state,data_in}; wr_ptr++ with natural wrap. Write while full is dropped.
//  Read: rd_enb && !empty at edge N -> data_out holds that byte from edge N (visible cycle N+1); rd_ptr++.
//   rd_enb while empty: no pointer change; data_out holds its last value.
//  Simultaneous read+write: both proceed if not empty/not full respectively; no bypass (empty FIFO never returns the
//   same-cycle write); a full FIFO rejects the write even when a read occurs in the same cycle.
//  Packet byte counter (7 bits): a read of a tag=1 entry loads data[7:2]+1 (payload + parity);
//   each later read of a tag=0 entry decrements it; the decrement from 1 to 0 pulses pkt_done in the cycle data_out
//   shows the parity byte. A header read while the counter is nonzero reloads it (truncated packet); no pulse.
//  Watchdog states: IDLE (vld_out=0 or rd_enb=1; count=0) -> WAIT (vld_out=1, rd_enb=0; count++) ->
//   FLUSH when count reaches TIMEOUT-1 and the idle condition still holds. Exactly TIMEOUT idle cycles then flush.
//   FLUSH (1 cycle): soft_reset=1; pointers, count and byte counter cleared; data_out=8'h00; -> IDLE.
//   Any rd_enb=1 or vld_out=0 in WAIT returns count to 0.
//  Flush priority: a write or read in the flush cycle is dropped; flush beats both.
//  Async reset during FLUSH or mid-packet: everything returns to reset values immediately, no pulse emitted.
// STRUCTURE
//  router_pkg: ROUTER_DATA_W=8, TAG_BIT=8, header field functions hdr_len(byte)=byte[7:2] and hdr_addr(byte)=byte[1:0],
//   and the watchdog state enum {WD_IDLE, WD_WAIT, WD_FLUSH}.
//  Sub-module router_timeout_wd (watchdog FSM + counter, TIMEOUT param) -> soft_reset; FIFO and byte counter stay inline.
// TESTING
//  1 Reset: assert resetn=0 mid-traffic -> data_out=00, vld_out=0, full=0, soft_reset=0 with no clock edge needed.
//  2 Packet: write header 8'h0D (len 3, addr 1) with lfd_state=1, then 3 payload bytes and a parity byte, then rd_enb x5
//    -> data_out 0D, p0, p1, p2, parity, each one cycle after its read; pkt_done pulses with parity; vld_out falls after read 5.
//  3 Full: 17 writes, no reads -> full=1 after 16; 17th byte dropped; 16 reads return bytes 1..16 in order.
//  4 Wrap: write 10/read 10 twice with overlapping traffic -> order preserved across pointer wrap, full never set.
//  5 Watchdog: 1 byte written, rd_enb=0 -> soft_reset pulses after exactly 30 idle cycles, vld_out=0 next cycle;
//    repeat with rd_enb=1 at idle cycle 29 -> no soft_reset.
//  6 Boundaries: simultaneous read+write on empty, full, and flush cycles -> behaviour per BEHAVIOUR rules.

Source files
------------

// File: rtl/router_pkg.sv
// Shared definitions for the router output channels: data widths, header field
// extraction and the watchdog state encoding.
package router_pkg;

    localparam int ROUTER_DATA_W = 8;
    localparam int TAG_BIT       = 8;

    typedef enum logic [1:0] {
        WD_IDLE,
        WD_WAIT,
        WD_FLUSH
    } wd_state_e;

    // Payload length carried in a header byte
    function automatic logic [5:0] hdr_len(input logic [ROUTER_DATA_W-1:0] b);
        return b[7:2];
    endfunction

    // Destination address carried in a header byte
    function automatic logic [1:0] hdr_addr(input logic [ROUTER_DATA_W-1:0] b);
        return b[1:0];
    endfunction

endpackage

// File: rtl/router_timeout_wd.sv
// Watchdog for one output channel: counts consecutive cycles in which data is
// pending but the destination is not reading, and requests a one-cycle flush.
//
//  state    | meaning
//  ---------+---------------------------------------------------------------
//  WD_IDLE  | nothing pending or destination reading; count held at 0
//  WD_WAIT  | data pending and ignored; count = consecutive ignored cycles
//  WD_FLUSH | soft_reset high for one cycle; channel cleared at its end
module router_timeout_wd
    import router_pkg::*;
#(
    parameter int TIMEOUT = 30
) (
    input  logic clock,
    input  logic resetn,
    input  logic vld_out,
    input  logic rd_enb,
    output logic soft_reset
);

    localparam int CW = $clog2(TIMEOUT + 1);

    wd_state_e     state;
    logic [CW-1:0] count;
    logic          ignored;

    assign ignored = vld_out && !rd_enb;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= WD_IDLE;
            count      <= '0;
            soft_reset <= 1'b0;
        end else begin
            soft_reset <= 1'b0;
            case (state)
                WD_IDLE: begin
                    if (ignored) begin
                        state <= WD_WAIT;
                        count <= CW'(1);
                    end else begin
                        count <= '0;
                    end
                end
                WD_WAIT: begin
                    if (!ignored) begin
                        state <= WD_IDLE;
                        count <= '0;
                    end else if (count == CW'(TIMEOUT - 1)) begin
                        // This is the TIMEOUT-th ignored cycle
                        state      <= WD_FLUSH;
                        count      <= '0;
                        soft_reset <= 1'b1;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                WD_FLUSH: begin
                    state <= WD_IDLE;
                    count <= '0;
                end
                default: begin
                    state <= WD_IDLE;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/router_dst_channel.sv
// Router output channel: tagged byte FIFO toward one destination port, with
// packet-end detection and a watchdog that flushes an ignored channel.
module router_dst_channel
    import router_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 30
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     write_enb,
    input  logic                     lfd_state,
    input  logic [ROUTER_DATA_W-1:0] data_in,
    input  logic                     rd_enb,
    output logic [ROUTER_DATA_W-1:0] data_out,
    output logic                     vld_out,
    output logic                     full,
    output logic                     soft_reset,
    output logic                     pkt_done
);

    localparam int AW = $clog2(DEPTH);

    logic [TAG_BIT:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [6:0]       byte_cnt;
    logic             empty;
    logic             do_wr;
    logic             do_rd;
    logic [TAG_BIT:0] rd_entry;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign vld_out  = !empty;
    // The flush cycle swallows any concurrent read or write
    assign do_wr    = write_enb && !full && !soft_reset;
    assign do_rd    = rd_enb && !empty && !soft_reset;
    assign rd_entry = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= {lfd_state, data_in};
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            byte_cnt <= '0;
            data_out <= '0;
            pkt_done <= 1'b0;
        end else if (soft_reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            byte_cnt <= '0;
            data_out <= '0;
            pkt_done <= 1'b0;
        end else begin
            pkt_done <= 1'b0;
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr   <= rd_ptr + 1'b1;
                data_out <= rd_entry[ROUTER_DATA_W-1:0];
                // Header reload also covers a truncated previous packet
                if (rd_entry[TAG_BIT]) begin
                    byte_cnt <= {1'b0, hdr_len(rd_entry[ROUTER_DATA_W-1:0])} + 7'd1;
                end else if (byte_cnt != 7'd0) begin
                    byte_cnt <= byte_cnt - 7'd1;
                    pkt_done <= (byte_cnt == 7'd1);
                end
            end
        end
    end

    router_timeout_wd #(
        .TIMEOUT(TIMEOUT)
    ) u_wd (
        .clock     (clock),
        .resetn    (resetn),
        .vld_out   (vld_out),
        .rd_enb    (rd_enb),
        .soft_reset(soft_reset)
    );

endmodule

// File: tb/tb_router_dst_channel.sv
// Scoreboard bench for router_dst_channel: a queue-based reference model
// predicts outputs per cycle; a monitor compares them on the falling edge.
module tb_router_dst_channel;

    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 30;

    logic       clock = 1'b0;
    logic       resetn;
    logic       write_enb;
    logic       lfd_state;
    logic [7:0] data_in;
    logic       rd_enb;
    logic [7:0] data_out;
    logic       vld_out;
    logic       full;
    logic       soft_reset;
    logic       pkt_done;

    router_dst_channel #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .write_enb (write_enb),
        .lfd_state (lfd_state),
        .data_in   (data_in),
        .rd_enb    (rd_enb),
        .data_out  (data_out),
        .vld_out   (vld_out),
        .full      (full),
        .soft_reset(soft_reset),
        .pkt_done  (pkt_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] dout;
        bit         pkt;
        bit         vld;
        bit         full;
        bit         sr;
    } exp_t;

    exp_t       exp_q[$];
    logic [8:0] mq[$];
    int         m_idle;
    bit         m_flush;
    logic [7:0] m_dout;
    bit         m_pkt;
    int         m_cnt;
    bit         done;
    int         n_chk;
    int         n_fail;

    function automatic void model_reset();
        mq.delete();
        m_idle  = 0;
        m_flush = 0;
        m_dout  = 8'h00;
        m_pkt   = 0;
        m_cnt   = 0;
    endfunction

    // One clock edge of the channel, described as queue operations
    function automatic void model_step(bit we, bit lfd, logic [7:0] d, bit re);
        int         sz;
        logic [8:0] e;
        sz = mq.size();
        if (m_flush) begin
            model_reset();
            return;
        end
        m_pkt = 0;
        if (sz != 0 && !re) begin
            m_idle++;
            if (m_idle == TIMEOUT) begin
                m_flush = 1;
                m_idle  = 0;
            end
        end else begin
            m_idle = 0;
        end
        if (re && sz != 0) begin
            e      = mq.pop_front();
            m_dout = e[7:0];
            if (e[8]) begin
                m_cnt = int'(e[7:2]) + 1;
            end else if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) m_pkt = 1;
            end
        end
        if (we && sz < DEPTH) mq.push_back({lfd, d});
    endfunction

    task automatic cyc(input bit we, input bit lfd, input logic [7:0] d, input bit re);
        exp_t x;
        write_enb = we;
        lfd_state = lfd;
        data_in   = d;
        rd_enb    = re;
        @(posedge clock);
        #1;
        model_step(we, lfd, d, re);
        x.dout = m_dout;
        x.pkt  = m_pkt;
        x.vld  = (mq.size() != 0);
        x.full = (mq.size() == DEPTH);
        x.sr   = m_flush;
        exp_q.push_back(x);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 8'h00, 0);
    endtask

    // Assert reset away from any edge; the monitor checks outputs while it is low
    task automatic do_reset();
        @(negedge clock);
        #2;
        resetn    = 1'b0;
        write_enb = 1'b0;
        rd_enb    = 1'b0;
        lfd_state = 1'b0;
        data_in   = 8'h00;
        #3;
        model_reset();
        exp_q.delete();
        @(posedge clock);
        #2;
        resetn = 1'b1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: the only process that counts comparisons
    initial begin
        exp_t x;
        n_chk  = 0;
        n_fail = 0;
        forever begin
            @(negedge clock or negedge resetn);
            if (!resetn) begin
                #1;
                if (!resetn) begin
                    check("rst_data_out", data_out, 8'h00);
                    check("rst_vld_out", {7'd0, vld_out}, 8'h00);
                    check("rst_full", {7'd0, full}, 8'h00);
                    check("rst_soft_reset", {7'd0, soft_reset}, 8'h00);
                    check("rst_pkt_done", {7'd0, pkt_done}, 8'h00);
                end
            end else if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                check("data_out", data_out, x.dout);
                check("pkt_done", {7'd0, pkt_done}, {7'd0, x.pkt});
                check("vld_out", {7'd0, vld_out}, {7'd0, x.vld});
                check("full", {7'd0, full}, {7'd0, x.full});
                check("soft_reset", {7'd0, soft_reset}, {7'd0, x.sr});
            end else if (done) begin
                $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
                $finish;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    // Stimulus
    initial begin
        int guard;
        int rd_pct;
        done      = 0;
        resetn    = 1'b0;
        write_enb = 1'b0;
        lfd_state = 1'b0;
        data_in   = 8'h00;
        rd_enb    = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #2;
        resetn = 1'b1;

        // Packet: header 0D (len 3), three payload bytes, parity, then five reads
        cyc(1, 1, 8'h0D, 0);
        cyc(1, 0, 8'hA1, 0);
        cyc(1, 0, 8'hB2, 0);
        cyc(1, 0, 8'hC3, 0);
        cyc(1, 0, 8'h5F, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 8'h00, 1);
        idle(2);

        // Async reset mid-packet
        cyc(1, 1, 8'h09, 0);
        cyc(1, 0, 8'h11, 0);
        cyc(0, 0, 8'h00, 1);
        do_reset();
        idle(1);

        // Full: 17 writes, then 16 reads
        for (int i = 1; i <= 17; i++) cyc(1, 0, 8'(i), 0);
        for (int i = 0; i < 16; i++) cyc(0, 0, 8'h00, 1);
        cyc(0, 0, 8'h00, 1);

        // Wrap: 10 writes, 10 overlapped write+read, 10 reads
        for (int i = 0; i < 10; i++) cyc(1, 0, 8'(8'h40 + i), 0);
        for (int i = 0; i < 10; i++) cyc(1, 0, 8'(8'h80 + i), 1);
        for (int i = 0; i < 10; i++) cyc(0, 0, 8'h00, 1);

        // Watchdog expiry, then a read on idle cycle 29 that prevents it
        cyc(1, 0, 8'h77, 0);
        idle(TIMEOUT + 2);
        cyc(1, 0, 8'h78, 0);
        idle(TIMEOUT - 2);
        cyc(0, 0, 8'h00, 1);
        idle(TIMEOUT + 2);

        // Read+write on empty: read ignored, write kept
        cyc(1, 0, 8'h55, 1);
        cyc(0, 0, 8'h00, 1);
        // Read+write on full: read proceeds, write dropped
        for (int i = 0; i < DEPTH; i++) cyc(1, 0, 8'(8'hC0 + i), 0);
        cyc(1, 0, 8'hEE, 1);
        for (int i = 0; i < DEPTH; i++) cyc(0, 0, 8'h00, 1);
        // Read+write during the flush cycle: both dropped
        cyc(1, 1, 8'h0C, 0);
        guard = 0;
        while (!m_flush && guard < 100) begin
            cyc(0, 0, 8'h00, 0);
            guard++;
        end
        cyc(1, 0, 8'hAB, 1);
        cyc(0, 0, 8'h00, 1);
        idle(2);

        // Randomized traffic with phases of slow readers to exercise the watchdog
        for (int p = 0; p < 8; p++) begin
            case (p % 4)
                0:       rd_pct = 0;
                1:       rd_pct = 30;
                2:       rd_pct = 60;
                default: rd_pct = 90;
            endcase
            for (int i = 0; i < 100; i++) begin
                cyc($urandom_range(0, 99) < 60, $urandom_range(0, 5) == 0,
                    8'($urandom_range(0, 255)), $urandom_range(0, 99) < rd_pct);
            end
        end
        for (int i = 0; i < DEPTH + 2; i++) cyc(0, 0, 8'h00, 1);

        @(posedge clock);
        #1;
        done = 1;
    end

endmodule
